// File: rtl/tff_count_ctrl.sv
// -----------------------------------------------------------------------------
// tff_count_ctrl
//
// Sequences an external bank of T flip-flops as a modulo-2^WIDTH binary
// counter. On an accepted start the bank is first cleared to its base value
// (all-zeros for up, all-ones for down). It is then stepped one count per
// cycle until the fed-back bank state equals the latched limit. A one-cycle
// done pulse marks completion. stop aborts with the bank left where it is.
//
// Ports
//   clk    : clock, rising edge active
//   rst_n  : asynchronous active-low reset
//   start  : begin a sequence (only looked at in IDLE)
//   stop   : abort request (looked at in CLEAR and RUN)
//   dir    : 0 = count up from all-zeros, 1 = count down from all-ones
//   limit  : terminal value, latched together with dir on accepted start
//   q      : present state of the T flip-flop bank (q[0] = LSB)
//   t      : toggle enables to the bank (bit i flips when t[i] = 1)
//   busy   : high while in CLEAR or RUN
//   done   : one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  // Toggle patterns for one binary step. Bit i toggles when every lower bit
  // is 1 (increment) or 0 (decrement); bit 0 always toggles.
  logic [WIDTH-1:0] t_up, t_dn;
  logic             carry_up, carry_dn;

  always_comb begin
    t_up     = '0;
    t_dn     = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i]  = carry_up;
      t_dn[i]  = carry_dn;
      carry_up = carry_up & q[i];
      carry_dn = carry_dn & ~q[i];
    end
  end

  logic at_limit;
  assign at_limit = (q == limit_q);

  // Next-state, register-load and toggle-enable decode.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    t       = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = dir;
          limit_d = limit;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          // Toggling the bits that differ from the base value lands the bank
          // on all-zeros (up) or all-ones (down) after one edge.
          t       = dir_q ? ~q : q;
          state_d = RUN;
        end
      end

      RUN: begin
        // stop takes priority over reaching the terminal value.
        if (stop) begin
          state_d = IDLE;
        end else if (at_limit) begin
          state_d = DONE;
        end else begin
          t = dir_q ? t_dn : t_up;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
    end
  end

  assign busy = (state_q == CLEAR) || (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
